// File: rtl/ft245_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : ft245_fifo_responder
// Function : Device-side FT245R FIFO pin emulation backed by RX/TX byte FIFOs.
// Revision : 1.0
// ============================================================================
module ft245_fifo_responder #(
   parameter int FIFO_AW       = 4,
   parameter int RD_DATA_DELAY = 2,
   parameter int RXF_PRECHARGE = 4,
   parameter int TXE_BUSY      = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       HOST_RX_DATA,
   input  logic             HOST_RX_VALID,
   output logic             HOST_RX_READY,
   output logic [7:0]       HOST_TX_DATA,
   output logic             HOST_TX_VALID,
   input  logic             HOST_TX_READY,
   output logic [FIFO_AW:0] RX_LEVEL,
   output logic [FIFO_AW:0] TX_LEVEL,
   output logic             RX_UNDERFLOW,
   output logic             TX_OVERFLOW,
   input  logic             RD,
   input  logic             WR,
   output logic             RXF,
   output logic             TXE,
   inout  wire  [7:0]       DATA_IO
);
   localparam int                 c_DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   c_FULL     = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   c_LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW-1:0] c_PTR_ONE  = FIFO_AW'(1);
   localparam logic [3:0]         c_DLY_LOAD = 4'(RD_DATA_DELAY - 2);
   localparam logic [3:0]         c_PRE_LOAD = 4'(RXF_PRECHARGE - 1);
   localparam logic [3:0]         c_BSY_LOAD = 4'(TXE_BUSY - 1);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_DELAY = 2'd1, R_DRIVE = 2'd2, R_PRECH = 2'd3} rd_state_t;
   typedef enum logic [0:0] {W_IDLE = 1'b0, W_BUSY = 1'b1} wr_state_t;

   // [0] first sync stage, [1] synchronized level, [2] previous level for edges
   logic [2:0]         r_rd_sync, r_wr_sync;
   logic [7:0]         r_data_s1, r_data_s2;
   logic               w_rd_fall, w_rd_rise, w_wr_fall;

   logic [7:0]         r_rx_mem [c_DEPTH];
   logic [7:0]         r_tx_mem [c_DEPTH];
   logic [FIFO_AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
   logic [FIFO_AW:0]   r_rx_level, r_tx_level, w_rx_level_nxt, w_tx_level_nxt;
   logic               w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;

   rd_state_t          r_rd_state, w_rd_state_nxt;
   logic [3:0]         r_rd_cnt, w_rd_cnt_nxt;
   logic               w_rd_start, r_rd_empty;
   logic [7:0]         r_rd_data;
   wr_state_t          r_wr_state, w_wr_state_nxt;
   logic [3:0]         r_wr_cnt, w_wr_cnt_nxt;
   logic               w_tx_drop;
   logic               r_rxf, r_txe, r_rx_underflow, r_tx_overflow, w_rxf_nxt, w_txe_nxt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_rd_sync <= '1;
         r_wr_sync <= '1;
         r_data_s1 <= '0;
         r_data_s2 <= '0;
      end else begin
         r_rd_sync <= {r_rd_sync[1:0], RD};
         r_wr_sync <= {r_wr_sync[1:0], WR};
         r_data_s1 <= DATA_IO;
         r_data_s2 <= r_data_s1;
      end
   end

   assign w_rd_fall = r_rd_sync[2] & ~r_rd_sync[1];
   assign w_rd_rise = ~r_rd_sync[2] & r_rd_sync[1];
   assign w_wr_fall = r_wr_sync[2] & ~r_wr_sync[1];

   assign HOST_RX_READY = (r_rx_level != c_FULL);
   assign w_rx_push     = HOST_RX_VALID && HOST_RX_READY;
   assign HOST_TX_VALID = (r_tx_level != '0);
   assign HOST_TX_DATA  = r_tx_mem[r_tx_rp];
   assign w_tx_pop      = HOST_TX_READY && HOST_TX_VALID;
   assign RX_LEVEL      = r_rx_level;
   assign TX_LEVEL      = r_tx_level;

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      w_rd_cnt_nxt   = r_rd_cnt;
      w_rd_start     = 1'b0;
      w_rx_pop       = 1'b0;
      case (r_rd_state)
         R_IDLE: begin
            if (w_rd_fall) begin
               w_rd_start = 1'b1;
               if (RD_DATA_DELAY <= 1) begin
                  w_rd_state_nxt = R_DRIVE;
               end else begin
                  w_rd_state_nxt = R_DELAY;
                  w_rd_cnt_nxt   = c_DLY_LOAD;
               end
            end
         end
         R_DELAY, R_DRIVE: begin
            if (w_rd_rise) begin
               // A byte is consumed only if one was presented when the strobe began
               w_rx_pop       = !r_rd_empty && (r_rx_level != '0);
               w_rd_state_nxt = R_PRECH;
               w_rd_cnt_nxt   = c_PRE_LOAD;
            end else if (r_rd_state == R_DELAY) begin
               if (r_rd_cnt == 4'd0) w_rd_state_nxt = R_DRIVE;
               else                  w_rd_cnt_nxt   = r_rd_cnt - 4'd1;
            end
         end
         default: begin
            if (r_rd_cnt == 4'd0) w_rd_state_nxt = R_IDLE;
            else                  w_rd_cnt_nxt   = r_rd_cnt - 4'd1;
         end
      endcase
   end

   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_wr_cnt_nxt   = r_wr_cnt;
      w_tx_push      = 1'b0;
      w_tx_drop      = 1'b0;
      if (r_wr_state == W_IDLE) begin
         if (w_wr_fall) begin
            w_tx_push      = (r_tx_level != c_FULL);
            w_tx_drop      = (r_tx_level == c_FULL);
            w_wr_state_nxt = W_BUSY;
            w_wr_cnt_nxt   = c_BSY_LOAD;
         end
      end else begin
         if (r_wr_cnt == 4'd0) w_wr_state_nxt = W_IDLE;
         else                  w_wr_cnt_nxt   = r_wr_cnt - 4'd1;
      end
   end

   always_comb begin
      w_rx_level_nxt = r_rx_level;
      w_tx_level_nxt = r_tx_level;
      if (w_rx_push && !w_rx_pop)      w_rx_level_nxt = r_rx_level + c_LVL_ONE;
      else if (!w_rx_push && w_rx_pop) w_rx_level_nxt = r_rx_level - c_LVL_ONE;
      if (w_tx_push && !w_tx_pop)      w_tx_level_nxt = r_tx_level + c_LVL_ONE;
      else if (!w_tx_push && w_tx_pop) w_tx_level_nxt = r_tx_level - c_LVL_ONE;
      case (w_rd_state_nxt)
         R_IDLE:  w_rxf_nxt = (w_rx_level_nxt == '0);
         R_PRECH: w_rxf_nxt = 1'b1;
         default: w_rxf_nxt = 1'b0;
      endcase
      w_txe_nxt = (w_wr_state_nxt == W_IDLE) ? (w_tx_level_nxt == c_FULL) : 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_rd_state     <= R_IDLE;
         r_rd_cnt       <= 4'd0;
         r_rd_empty     <= 1'b0;
         r_rd_data      <= 8'h00;
         r_wr_state     <= W_IDLE;
         r_wr_cnt       <= 4'd0;
         r_rx_wp        <= '0;
         r_rx_rp        <= '0;
         r_tx_wp        <= '0;
         r_tx_rp        <= '0;
         r_rx_level     <= '0;
         r_tx_level     <= '0;
         r_rxf          <= 1'b1;
         r_txe          <= 1'b1;
         r_rx_underflow <= 1'b0;
         r_tx_overflow  <= 1'b0;
      end else begin
         r_rd_state     <= w_rd_state_nxt;
         r_rd_cnt       <= w_rd_cnt_nxt;
         r_wr_state     <= w_wr_state_nxt;
         r_wr_cnt       <= w_wr_cnt_nxt;
         r_rx_level     <= w_rx_level_nxt;
         r_tx_level     <= w_tx_level_nxt;
         r_rxf          <= w_rxf_nxt;
         r_txe          <= w_txe_nxt;
         r_rx_underflow <= w_rd_start && (r_rx_level == '0);
         r_tx_overflow  <= w_tx_drop;
         if (w_rd_start) begin
            r_rd_empty <= (r_rx_level == '0);
            r_rd_data  <= (r_rx_level == '0) ? 8'h00 : r_rx_mem[r_rx_rp];
         end
         if (w_rx_push) r_rx_wp <= r_rx_wp + c_PTR_ONE;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_PTR_ONE;
         if (w_tx_push) r_tx_wp <= r_tx_wp + c_PTR_ONE;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_PTR_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= HOST_RX_DATA;
      if (w_tx_push) r_tx_mem[r_tx_wp] <= r_data_s2;
   end

   assign RXF          = r_rxf;
   assign TXE          = r_txe;
   assign RX_UNDERFLOW = r_rx_underflow;
   assign TX_OVERFLOW  = r_tx_overflow;
   // State register resets asynchronously, so the bus is released the moment RST falls
   assign DATA_IO      = (r_rd_state == R_DRIVE) ? r_rd_data : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_ft245_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_fifo_responder
// Function : Randomized and directed bench for ft245_fifo_responder.
// Revision : 1.0
// ============================================================================
module tb_ft245_fifo_responder;
   localparam int DELAY = 2;
   localparam int PRECH = 4;
   localparam int BUSY  = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] HOST_RX_DATA = 8'h00;
   logic       HOST_RX_VALID = 1'b0;
   logic       HOST_RX_READY;
   logic [7:0] HOST_TX_DATA;
   logic       HOST_TX_VALID;
   logic       HOST_TX_READY = 1'b0;
   logic [4:0] RX_LEVEL, TX_LEVEL;
   logic       RX_UNDERFLOW, TX_OVERFLOW;
   logic       RD = 1'b1;
   logic       WR = 1'b1;
   logic       RXF, TXE;
   wire  [7:0] data_io;
   logic [7:0] tb_drv = 8'h00;
   logic       tb_oe = 1'b0;
   logic       rand_host = 1'b0;

   int checks = 0;
   int failures = 0;
   int udf_cnt = 0;
   int ovf_cnt = 0;

   always #5 CLK = ~CLK;

   assign data_io = tb_oe ? tb_drv : 8'hzz;
   for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup (data_io[gi]);
   end

   ft245_fifo_responder #(
      .FIFO_AW(4), .RD_DATA_DELAY(DELAY), .RXF_PRECHARGE(PRECH), .TXE_BUSY(BUSY)
   ) dut (
      .CLK(CLK), .RST(RST),
      .HOST_RX_DATA(HOST_RX_DATA), .HOST_RX_VALID(HOST_RX_VALID), .HOST_RX_READY(HOST_RX_READY),
      .HOST_TX_DATA(HOST_TX_DATA), .HOST_TX_VALID(HOST_TX_VALID), .HOST_TX_READY(HOST_TX_READY),
      .RX_LEVEL(RX_LEVEL), .TX_LEVEL(TX_LEVEL),
      .RX_UNDERFLOW(RX_UNDERFLOW), .TX_OVERFLOW(TX_OVERFLOW),
      .RD(RD), .WR(WR), .RXF(RXF), .TXE(TXE), .DATA_IO(data_io)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFOs as queues, read/write windows as cycle-number intervals
   bit [7:0] mrx[$];
   bit [7:0] mtx[$];
   int       cyc, m_fall_cyc, m_prech_end, m_busy_end;
   bit       rh1, rh2, rh3, wh1, wh2, wh3;
   bit [7:0] dh1, dh2;
   bit       m_rd_act, m_rd_empty;
   bit [7:0] m_rd_byte;
   bit       e_rxf, e_txe, e_udf, e_ovf, e_drive;
   bit       rfall, rrise, wfall, rxpush, rxpop, txpush, txpop;

   always @(posedge CLK) begin
      if (!RST) begin
         mrx.delete(); mtx.delete();
         cyc = 0; m_prech_end = 0; m_busy_end = 0; m_fall_cyc = 0;
         {rh1, rh2, rh3, wh1, wh2, wh3} = 6'h3F;
         dh1 = 8'hFF; dh2 = 8'hFF;
         m_rd_act = 0; m_rd_empty = 0; m_rd_byte = 8'h00;
         e_rxf = 1; e_txe = 1; e_udf = 0; e_ovf = 0; e_drive = 0;
      end else begin
         cyc++;
         rfall  = rh3 & ~rh2;
         rrise  = ~rh3 & rh2;
         wfall  = wh3 & ~wh2;
         rxpush = HOST_RX_VALID && (mrx.size() < 16);
         txpop  = HOST_TX_READY && (mtx.size() > 0);
         rxpop  = 0; txpush = 0; e_udf = 0; e_ovf = 0;
         if (m_rd_act && rrise) begin
            rxpop       = !m_rd_empty && (mrx.size() > 0);
            m_rd_act    = 0;
            m_prech_end = cyc + PRECH;
         end else if (!m_rd_act && rfall && (cyc - 1) >= m_prech_end) begin
            m_rd_act   = 1;
            m_fall_cyc = cyc - 1;
            m_rd_empty = (mrx.size() == 0);
            m_rd_byte  = m_rd_empty ? 8'h00 : mrx[0];
            e_udf      = m_rd_empty;
         end
         if (wfall && (cyc - 1) >= m_busy_end) begin
            if (mtx.size() == 16) e_ovf = 1;
            else                  txpush = 1;
            m_busy_end = cyc + BUSY;
         end
         if (rxpop)  void'(mrx.pop_front());
         if (rxpush) mrx.push_back(HOST_RX_DATA);
         if (txpop)  void'(mtx.pop_front());
         if (txpush) mtx.push_back(dh2);
         e_drive = m_rd_act && (cyc >= m_fall_cyc + DELAY);
         if (m_rd_act)               e_rxf = 0;
         else if (cyc < m_prech_end) e_rxf = 1;
         else                        e_rxf = (mrx.size() == 0);
         e_txe = (cyc < m_busy_end) ? 1'b1 : (mtx.size() == 16);
         rh3 = rh2; rh2 = rh1; rh1 = RD;
         wh3 = wh2; wh2 = wh1; wh1 = WR;
         dh2 = dh1; dh1 = tb_oe ? tb_drv : 8'hFF;
      end
   end

   always @(posedge CLK) begin
      #1;
      chk("RXF", RXF, e_rxf);
      chk("TXE", TXE, e_txe);
      chk("RX_LEVEL", RX_LEVEL, mrx.size());
      chk("TX_LEVEL", TX_LEVEL, mtx.size());
      chk("HOST_RX_READY", HOST_RX_READY, mrx.size() < 16);
      chk("HOST_TX_VALID", HOST_TX_VALID, mtx.size() > 0);
      if (mtx.size() > 0) chk("HOST_TX_DATA", HOST_TX_DATA, mtx[0]);
      chk("RX_UNDERFLOW", RX_UNDERFLOW, e_udf);
      chk("TX_OVERFLOW", TX_OVERFLOW, e_ovf);
      if (!tb_oe) chk("DATA_IO", data_io, e_drive ? m_rd_byte : 8'hFF);
      if (RX_UNDERFLOW) udf_cnt++;
      if (TX_OVERFLOW)  ovf_cnt++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge CLK);
         if (rand_host) begin
            HOST_RX_VALID = ($urandom_range(0, 2) == 0);
            HOST_RX_DATA  = 8'($urandom_range(0, 254));
            HOST_TX_READY = ($urandom_range(0, 2) == 0);
         end
      end
   endtask

   task automatic rd_strobe(input int low, input int gap, output logic [7:0] got);
      RD = 1'b0;
      got = 8'hFF;
      repeat (low) begin
         tick();
         got = data_io;
      end
      RD = 1'b1;
      tick(gap);
   endtask

   task automatic wr_strobe(input logic [7:0] d, input int low, input int gap);
      tb_drv = d;
      tb_oe  = 1'b1;
      WR     = 1'b0;
      tick(low);
      WR = 1'b1;
      tick(2);
      tb_oe = 1'b0;
      tick(gap);
   endtask

   task automatic push_rx(input logic [7:0] d);
      HOST_RX_VALID = 1'b1;
      HOST_RX_DATA  = d;
      tick();
      HOST_RX_VALID = 1'b0;
   endtask

   logic [7:0] got;

   initial begin
      // Reset release with no traffic
      tick(3);
      chk("reset_TXE", TXE, 1);
      chk("reset_RXF", RXF, 1);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("release_TXE", TXE, 0);
      chk("release_RXF", RXF, 1);
      chk("release_Z", data_io, 8'hFF);
      tick(3);

      // Single byte read: data from D+2, released after rise, precharge
      push_rx(8'hA5);
      tick(2);
      RD = 1'b0;
      repeat (3) @(posedge CLK);
      #1 chk("rd_before_D2", data_io, 8'hFF);
      @(posedge CLK);
      #1 chk("rd_at_D2", data_io, 8'hA5);
      tick();
      RD = 1'b1;
      repeat (2) @(posedge CLK);
      #1 chk("rd_hold", data_io, 8'hA5);
      @(posedge CLK);
      #1 chk("rd_release", data_io, 8'hFF);
      chk("rd_prech_rxf", RXF, 1);
      repeat (6) @(posedge CLK);
      #1 chk("rd_empty_rxf", RXF, 1);
      tick();

      // Three queued bytes read back in order
      push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
      tick(2);
      rd_strobe(6, 7, got);
      chk("order_1", got, 8'h11);
      chk("rxf_relow", RXF, 0);
      rd_strobe(6, 7, got);
      chk("order_2", got, 8'h22);
      rd_strobe(6, 7, got);
      chk("order_3", got, 8'h33);

      // Read on empty FIFO
      udf_cnt = 0;
      rd_strobe(6, 7, got);
      chk("udf_data", got, 8'h00);
      chk("udf_pulse", udf_cnt, 1);

      // Single write
      tb_drv = 8'h5C; tb_oe = 1'b1; WR = 1'b0;
      repeat (3) @(posedge CLK);
      #1 chk("wr_txe_busy", TXE, 1);
      chk("wr_valid", HOST_TX_VALID, 1);
      chk("wr_data", HOST_TX_DATA, 8'h5C);
      repeat (4) @(posedge CLK);
      #1 chk("wr_txe_free", TXE, 0);
      tick();
      WR = 1'b1;
      tick(2);
      tb_oe = 1'b0;
      HOST_TX_READY = 1'b1;
      tick();
      HOST_TX_READY = 1'b0;
      tick(2);

      // Fill TX FIFO, then overflow
      for (int i = 0; i < 16; i++) wr_strobe(8'(i + 1), 2, 5);
      chk("full_level", TX_LEVEL, 16);
      chk("full_txe", TXE, 1);
      ovf_cnt = 0;
      wr_strobe(8'hEE, 2, 5);
      chk("ovf_pulse", ovf_cnt, 1);
      chk("ovf_level", TX_LEVEL, 16);
      chk("ovf_head", HOST_TX_DATA, 8'h01);
      HOST_TX_READY = 1'b1;
      tick(16);
      HOST_TX_READY = 1'b0;
      tick();
      chk("drain_level", TX_LEVEL, 0);

      // Push on the same edge as an RD-rise pop keeps the level
      push_rx(8'h77);
      tick(2);
      RD = 1'b0;
      tick(6);
      chk("pp_data", data_io, 8'h77);
      RD = 1'b1;
      tick(2);
      HOST_RX_VALID = 1'b1;
      HOST_RX_DATA  = 8'h88;
      tick();
      HOST_RX_VALID = 1'b0;
      #1 chk("pp_level", RX_LEVEL, 1);
      tick(7);

      // Reset while driving releases the bus immediately
      RD = 1'b0;
      tick(5);
      chk("mid_drive", data_io, 8'h88);
      RST = 1'b0;
      #1 chk("mid_rst_z", data_io, 8'hFF);
      RD = 1'b1;
      tick(2);
      chk("mid_rst_level", RX_LEVEL, 0);
      chk("mid_rst_rxf", RXF, 1);
      RST = 1'b1;
      tick(3);

      // Randomized traffic against the model
      rand_host = 1'b1;
      for (int op = 0; op < 80; op++) begin
         case ($urandom_range(0, 2))
            0:       rd_strobe(int'($urandom_range(1, 8)), int'($urandom_range(6, 9)), got);
            1:       wr_strobe(8'($urandom_range(0, 255)), int'($urandom_range(1, 6)), int'($urandom_range(5, 8)));
            default: tick(int'($urandom_range(1, 4)));
         endcase
      end
      rand_host = 1'b0;
      HOST_RX_VALID = 1'b0;
      HOST_TX_READY = 1'b0;
      tick(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
